// File: rtl/vga_timing_pkg.sv
// VGA timing constants, control-bit bundle and the screen-region decoder.
// Latency: n/a (package). Backpressure: n/a.
// Contents: default 640x480@60 timing, derived totals and sync windows,
//           vga_ctrl_t (hsync/vsync/video_on) and decode_region().
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL      = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL      = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
    localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

    typedef struct packed {
        logic hsync;     // active low
        logic vsync;     // active low
        logic video_on;
    } vga_ctrl_t;

    localparam vga_ctrl_t CTRL_RESET = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0};

    // Sync windows are half-open [start, end); both syncs are active low.
    function automatic vga_ctrl_t decode_region(
        input logic [CNT_W-1:0] h,
        input logic [CNT_W-1:0] v,
        input logic [CNT_W-1:0] h_vis,
        input logic [CNT_W-1:0] h_ss,
        input logic [CNT_W-1:0] h_se,
        input logic [CNT_W-1:0] v_vis,
        input logic [CNT_W-1:0] v_ss,
        input logic [CNT_W-1:0] v_se
    );
        vga_ctrl_t c;
        c.hsync    = !((h >= h_ss) && (h < h_se));
        c.vsync    = !((v >= v_ss) && (v < v_se));
        c.video_on = (h < h_vis) && (v < v_vis);
        return c;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with increment enable and wrap strobe.
// Latency: count_o updates on the edge after inc_i; nxt_o/wrap_o are combinational.
// Backpressure: none; holds when inc_i is low.
// Ports: clk_i, rst_i (sync, active high), inc_i -> count_o, nxt_o (next-state), wrap_o.
module mod_counter #(
    parameter int W   = 10,
    parameter int MOD = 800
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] nxt_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign wrap_o = inc_i && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    // Exposed so the owner can register decodes that line up with the new count.
    assign nxt_o   = count_d;

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing: pixel-clock divider, h/v counters, registered sync/blank decodes.
// Latency: decodes and frame_start are registered alongside the counters (same edge).
// Backpressure: en low freezes divider, counters and decodes; strobes forced low.
// Ports: clk, rst (sync, active high), en -> h_count, v_count, hsync, vsync,
//        video_on, pixel_tick, frame_start.
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             pixel_tick,
    output logic             frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_VIS_L = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] H_SS_L  = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] H_SE_L  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_VIS_L = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] V_SS_L  = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] V_SE_L  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam int               DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick;

    logic [CNT_W-1:0] h_q;
    logic [CNT_W-1:0] h_nxt;
    logic             h_wrap;
    logic [CNT_W-1:0] v_q;
    logic [CNT_W-1:0] v_nxt;
    logic             v_wrap;

    vga_ctrl_t ctrl_q;
    vga_ctrl_t ctrl_d;
    logic      fs_q;
    logic      fs_d;

    // Gating with rst keeps the strobe low during reset even when CLK_DIV=1,
    // where the divider sits at its terminal value permanently.
    assign tick = en && !rst && (div_q == DIV_MAX);

    always_comb begin
        div_d = div_q;
        if (tick) begin
            div_d = '0;
        end else if (en) begin
            div_d = div_q + DIV_W'(1);
        end
    end

    mod_counter #(
        .W   (CNT_W),
        .MOD (H_TOTAL)
    ) u_h_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (tick),
        .count_o (h_q),
        .nxt_o   (h_nxt),
        .wrap_o  (h_wrap)
    );

    mod_counter #(
        .W   (CNT_W),
        .MOD (V_TOTAL)
    ) u_v_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (h_wrap),
        .count_o (v_q),
        .nxt_o   (v_nxt),
        .wrap_o  (v_wrap)
    );

    // Decodes track the counters' next values so the registered outputs
    // always describe the position they are presented with. They only move on
    // a tick, so video_on stays low out of reset until the first advance.
    always_comb begin
        ctrl_d = ctrl_q;
        if (tick) begin
            ctrl_d = decode_region(h_nxt, v_nxt, H_VIS_L, H_SS_L, H_SE_L,
                                   V_VIS_L, V_SS_L, V_SE_L);
        end
    end

    assign fs_d = tick && h_wrap && v_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            ctrl_q <= CTRL_RESET;
            fs_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            ctrl_q <= ctrl_d;
            fs_q   <= fs_d;
        end
    end

    assign h_count     = h_q;
    assign v_count     = v_q;
    assign hsync       = ctrl_q.hsync;
    assign vsync       = ctrl_q.vsync;
    assign video_on    = ctrl_q.video_on;
    assign pixel_tick  = tick;
    // Pausing in the wrap cycle must not leave a stale strobe visible.
    assign frame_start = fs_q && en;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed self-checking bench: default-timing build for line-level checks,
// a reduced-timing build (16x12, CLK_DIV=2) for full frames and mid-frame reset,
// and a CLK_DIV=1 build for the undivided pixel clock.
module tb_vga_timing_generator;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Default build
    logic       rst_a, en_a;
    logic [9:0] ha, va;
    logic       hsa, vsa, voa, pta, fsa;

    // Reduced build: H 8/2/3/3 (total 16, hsync low 10..12), V 6/2/2/2 (total 12, vsync low 8..9)
    logic       rst_b, en_b;
    logic [9:0] hb, vb;
    logic       hsb, vsb, vob, ptb, fsb;

    logic       rst_c, en_c;
    logic [9:0] hc, vc;
    logic       hsc, vsc, voc, ptc, fsc;

    vga_timing_generator u_def (
        .clk(clk), .rst(rst_a), .en(en_a),
        .h_count(ha), .v_count(va), .hsync(hsa), .vsync(vsa),
        .video_on(voa), .pixel_tick(pta), .frame_start(fsa)
    );

    vga_timing_generator #(
        .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) u_small (
        .clk(clk), .rst(rst_b), .en(en_b),
        .h_count(hb), .v_count(vb), .hsync(hsb), .vsync(vsb),
        .video_on(vob), .pixel_tick(ptb), .frame_start(fsb)
    );

    vga_timing_generator #(
        .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) u_div1 (
        .clk(clk), .rst(rst_c), .en(en_c),
        .h_count(hc), .v_count(vc), .hsync(hsc), .vsync(vsc),
        .video_on(voc), .pixel_tick(ptc), .frame_start(fsc)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_a = 1'b1; en_a = 1'b1;
        step(); step();
        n_checks++;
        if ({ha, va, hsa, vsa, voa, pta, fsa} !== {10'd0, 10'd0, 5'b11000}) begin
            n_fail++;
            $display("FAIL reset_state: h=%0d v=%0d hs=%b vs=%b vo=%b pt=%b fs=%b, want 0 0 1 1 0 0 0",
                     ha, va, hsa, vsa, voa, pta, fsa);
        end
        rst_a = 1'b0;
        step();
        n_checks++;
        if ({ha, va, voa, pta} !== {10'd0, 10'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL first_tick_phase: h=%0d v=%0d vo=%b pt=%b, want 0 0 0 1", ha, va, voa, pta);
        end
        step();
        n_checks++;
        if ({ha, va, voa, pta} !== {10'd1, 10'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL first_tick_move: h=%0d v=%0d vo=%b pt=%b, want 1 0 1 0", ha, va, voa, pta);
        end
    endtask

    task automatic test_freeze_hsync();
        int ticks, hs_low, vid, first_low_h, last_low_h;
        for (int i = 0; i < 3000 && ha != 10'd655; i++) step();
        n_checks++;
        if (ha !== 10'd655) begin
            n_fail++;
            $display("FAIL reach_655: h=%0d, want 655 (timeout)", ha);
        end
        en_a = 1'b0;
        for (int i = 0; i < 37; i++) begin
            step();
            n_checks++;
            if ({ha, va, hsa, vsa, voa, pta, fsa} !== {10'd655, 10'd0, 5'b11000}) begin
                n_fail++;
                $display("FAIL freeze_cycle_%0d: h=%0d v=%0d hs=%b vs=%b vo=%b pt=%b fs=%b, want 655 0 1 1 0 0 0",
                         i, ha, va, hsa, vsa, voa, pta, fsa);
            end
        end
        en_a = 1'b1;
        step();
        n_checks++;
        if ({ha, hsa, pta} !== {10'd655, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL resume_phase: h=%0d hs=%b pt=%b, want 655 1 1", ha, hsa, pta);
        end
        step();
        n_checks++;
        if ({ha, hsa, pta} !== {10'd656, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL hsync_fall: h=%0d hs=%b pt=%b, want 656 0 0", ha, hsa, pta);
        end
        ticks = 0; hs_low = 0; vid = 0; first_low_h = -1; last_low_h = -1;
        for (int i = 0; i < 2000 && ticks < 800; i++) begin
            step();
            if (pta) begin
                ticks++;
                if (!hsa) begin
                    hs_low++;
                    if (first_low_h < 0) first_low_h = int'(ha);
                    last_low_h = int'(ha);
                end
                if (voa) vid++;
            end
        end
        n_checks++;
        if (hs_low != 96) begin
            n_fail++;
            $display("FAIL hsync_low_ticks: got %0d, want 96", hs_low);
        end
        n_checks++;
        if (first_low_h != 656 || last_low_h != 751) begin
            n_fail++;
            $display("FAIL hsync_window: got %0d..%0d, want 656..751", first_low_h, last_low_h);
        end
        n_checks++;
        if (vid != 640) begin
            n_fail++;
            $display("FAIL video_ticks_per_line: got %0d, want 640", vid);
        end
        n_checks++;
        if ({ha, va} !== {10'd655, 10'd1}) begin
            n_fail++;
            $display("FAIL line_end_pos: h=%0d v=%0d, want 655 1", ha, va);
        end
    endtask

    // 192 ticks per frame at 2 clocks per tick -> frame_start after edges 384 and 768.
    task automatic test_frames();
        int t, eh, ev, fs_cnt, fs_k0, fs_k1;
        logic [9:0] eh_l, ev_l;
        logic ehs, evs, evo, ept, efs;
        rst_b = 1'b1; en_b = 1'b1;
        step(); step();
        rst_b = 1'b0;
        fs_cnt = 0; fs_k0 = -1; fs_k1 = -1;
        for (int k = 1; k <= 772; k++) begin
            step();
            t    = k / 2;
            eh   = t % 16;
            ev   = (t / 16) % 12;
            eh_l = 10'(eh);
            ev_l = 10'(ev);
            ehs  = !(eh >= 10 && eh < 13);
            evs  = !(ev >= 8 && ev < 10);
            evo  = (t >= 1) && (eh < 8) && (ev < 6);
            ept  = (k % 2) == 1;
            efs  = ((k % 2) == 0) && (t > 0) && ((t % 192) == 0);
            n_checks++;
            if ({hb, vb, hsb, vsb, vob, ptb, fsb} !== {eh_l, ev_l, ehs, evs, evo, ept, efs}) begin
                n_fail++;
                $display("FAIL frame_clk_%0d: h=%0d v=%0d hs=%b vs=%b vo=%b pt=%b fs=%b, want %0d %0d %b %b %b %b %b",
                         k, hb, vb, hsb, vsb, vob, ptb, fsb, eh, ev, ehs, evs, evo, ept, efs);
            end
            if (fsb) begin
                fs_cnt++;
                if (fs_cnt == 1) fs_k0 = k;
                if (fs_cnt == 2) fs_k1 = k;
            end
        end
        n_checks++;
        if (fs_cnt != 2 || fs_k0 != 384 || fs_k1 != 768) begin
            n_fail++;
            $display("FAIL frame_start_clocks: count=%0d at %0d,%0d, want 2 at 384,768", fs_cnt, fs_k0, fs_k1);
        end
    endtask

    task automatic test_reset_mid_sync();
        for (int i = 0; i < 500 && !(hb == 10'd11 && vb == 10'd8); i++) step();
        n_checks++;
        if ({hb, vb, hsb, vsb} !== {10'd11, 10'd8, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_sync_reach: h=%0d v=%0d hs=%b vs=%b, want 11 8 0 0", hb, vb, hsb, vsb);
        end
        rst_b = 1'b1;
        step();
        n_checks++;
        if ({hb, vb, hsb, vsb, vob, ptb, fsb} !== {10'd0, 10'd0, 5'b11000}) begin
            n_fail++;
            $display("FAIL mid_reset_state: h=%0d v=%0d hs=%b vs=%b vo=%b pt=%b fs=%b, want 0 0 1 1 0 0 0",
                     hb, vb, hsb, vsb, vob, ptb, fsb);
        end
        rst_b = 1'b0;
        step();
        n_checks++;
        if ({hb, vob, ptb} !== {10'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_reset_tick_phase: h=%0d vo=%b pt=%b, want 0 0 1", hb, vob, ptb);
        end
        step();
        n_checks++;
        if ({hb, vb, vob, ptb} !== {10'd1, 10'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset_first_move: h=%0d v=%0d vo=%b pt=%b, want 1 0 1 0", hb, vb, vob, ptb);
        end
    endtask

    task automatic test_div1();
        int eh, ev, fs_cnt;
        logic [9:0] eh_l, ev_l;
        logic efs;
        rst_c = 1'b1; en_c = 1'b1;
        step();
        n_checks++;
        if ({hc, vc, ptc, fsc} !== {10'd0, 10'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL div1_reset: h=%0d v=%0d pt=%b fs=%b, want 0 0 0 0", hc, vc, ptc, fsc);
        end
        rst_c = 1'b0;
        fs_cnt = 0;
        for (int k = 1; k <= 200; k++) begin
            step();
            eh   = k % 16;
            ev   = (k / 16) % 12;
            eh_l = 10'(eh);
            ev_l = 10'(ev);
            efs  = (k == 192);
            if (fsc) fs_cnt++;
            n_checks++;
            if ({hc, vc, ptc, fsc} !== {eh_l, ev_l, 1'b1, efs}) begin
                n_fail++;
                $display("FAIL div1_clk_%0d: h=%0d v=%0d pt=%b fs=%b, want %0d %0d 1 %b",
                         k, hc, vc, ptc, fsc, eh, ev, efs);
            end
        end
        n_checks++;
        if (fs_cnt != 1) begin
            n_fail++;
            $display("FAIL div1_frame_len: frame_start count=%0d, want 1 in 200 clocks", fs_cnt);
        end
        en_c = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({hc, vc, ptc} !== {10'd8, 10'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL div1_pause_%0d: h=%0d v=%0d pt=%b, want 8 0 0", i, hc, vc, ptc);
            end
        end
        en_c = 1'b1;
        step();
        n_checks++;
        if ({hc, ptc} !== {10'd9, 1'b1}) begin
            n_fail++;
            $display("FAIL div1_resume: h=%0d pt=%b, want 9 1", hc, ptc);
        end
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b0;
        rst_c = 1'b1; en_c = 1'b0;
        @(negedge clk);
        test_reset();
        test_freeze_hsync();
        test_frames();
        test_reset_mid_sync();
        test_div1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
